cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
// Direct-mapped cache control FSM that sits upstream of the cachelines data array and drives its set/word/byte
// selects and write strobe. It holds tag and valid state, accepts one CPU load/store at a time, refills a line
// word-serially from memory on a read miss, and is write-through with no-allocate on write miss.
// PARAMETERS
// XLEN              32  data/address width
// NUM_SETS          4   number of lines; must equal 2**SET_SIZE
// SET_SIZE          2   set index width
// WORDS_PER_LINE    8   words per line; must equal 2**WORD_SELECT_SIZE
// WORD_SELECT_SIZE  3   word index width
// BYTE_SELECT_SIZE  2   byte offset width
// (localparam TAG_SIZE = XLEN-SET_SIZE-WORD_SELECT_SIZE-BYTE_SELECT_SIZE; addr = {tag,set,word,byte})
// PORTS
// clk               in   1     clock, all state on posedge
// rst_n             in   1     asynchronous active-low reset
// req_valid         in   1     CPU request present
// req_ready         out  1     controller can accept (high only in IDLE)
// req_we            in   1     1=store, 0=load
// req_addr          in   XLEN  byte address
// req_size          in   enum  memory_operation_size_e: BYTE/HALF/WORD
// req_wdata         in   XLEN  store data, LSB-aligned
// resp_valid        out  1     one-cycle completion pulse, no backpressure
// resp_rdata        out  XLEN  load data (zero-extended by array); 0 for stores
// resp_err          out  1     qualifies resp_valid: misaligned request
// cl_perform_write  out  1     array write strobe
// cl_set            out  SET_SIZE          array set select
// cl_word_select    out  WORD_SELECT_SIZE  array word select
// cl_byte_select    out  BYTE_SELECT_SIZE  array byte select
// cl_op_size        out  enum  array access size
// cl_word_to_store  out  XLEN  array write data
// cl_fetched_word   in   XLEN  array combinational read data
// mem_req, mem_we   out  1,1   memory request / write; held until mem_ready
// mem_addr          out  XLEN  memory byte address
// mem_size          out  enum  memory access size
// mem_wdata         out  XLEN  memory write data
// mem_ready         in   1     request accepted this cycle (mem_req && mem_ready)
// mem_rvalid        in   1     read data valid; exactly one per accepted read
// mem_rdata         in   XLEN  read data
// BEHAVIOUR
// Reset: state=IDLE, all valid bits=0, fill_idx=0, req_ready=1, resp_valid/resp_err/cl_perform_write/mem_req=0.
// Tags and data array are not reset. Reset mid-fill aborts it; the line stays invalid and no resp issues.
// IDLE: req_ready=1; on req_valid, capture we/addr/size/wdata -> LOOKUP. Never accepts a second request.
// LOOKUP: cl_* driven from captured addr/size; hit = valid[set] && tag[set]==req_tag.
//  misaligned (HALF with addr[0]!=0, WORD with addr[1:0]!=0): resp_valid=1, resp_err=1, no array/mem access -> IDLE.
//  load hit: resp_valid=1, resp_rdata=cl_fetched_word this cycle -> IDLE (latency 1 cycle after accept).
//  store hit: cl_perform_write=1 this cycle -> WT_REQ. store miss: no array write, valid untouched -> WT_REQ.
//  load miss: valid[set]<=0, fill_idx<=0 -> FILL_REQ.
// FILL_REQ: mem_req=1, mem_we=0, mem_size=WORD, mem_addr={req_tag,set,fill_idx,2'b00}; on mem_ready -> FILL_WAIT.
// FILL_WAIT: on mem_rvalid: cl_perform_write=1, cl_set=set, cl_word_select=fill_idx, cl_op_size=WORD,
//  cl_word_to_store=mem_rdata. If fill_idx==WORDS_PER_LINE-1: tag[set]<=req_tag, valid[set]<=1 -> REPLAY;
//  else fill_idx++ -> FILL_REQ. Fill is always words 0..N-1 regardless of the requested word.
// REPLAY: cl_* driven from captured request; resp_valid=1, resp_rdata=cl_fetched_word -> IDLE.
// WT_REQ: mem_req=1, mem_we=1, mem_addr=req_addr, mem_size=req_size, mem_wdata=req_wdata;
//  in the cycle mem_req&&mem_ready: resp_valid=1 -> IDLE.
// cl_perform_write is asserted only in LOOKUP (store hit) and FILL_WAIT (rvalid); mem_rvalid outside FILL_WAIT is ignored.
// mem_req is held stable, with stable address/data, until accepted; no combinational path from mem_ready to mem_req.
// TESTING
// Cold load WORD 0x0000_0024 -> 8 mem reads 0x20..0x3C in order, 8 array writes, valid[1]=1, resp_rdata=word 1 of line.
// Repeat load 0x24 -> resp_valid exactly 1 cycle after accept, no mem_req.
// Store BYTE 0xA5 to 0x26 after fill -> array byte 2 of word 1 written, mem write 0x26 BYTE, load 0x24 returns 0x??A5????.
// Store WORD to 0x100 (miss) -> mem write only, valid unchanged, later load 0x100 misses and fills.
// HALF at 0x21 / WORD at 0x22 -> resp_err=1 one cycle after accept, no mem_req, no array write.
// rst_n low during FILL_WAIT word 3 -> all valid=0, IDLE; next load of same line refills from word 0.

Source files
------------

// File: rtl/cache_controller_if.sv
// Shared size enum plus the controller's bus bundle.
// cache_controller_if groups three buses:
//   CPU side    : req_valid/req_ready/req_we/req_addr/req_size/req_wdata,
//                 resp_valid/resp_rdata/resp_err
//   array side  : cl_perform_write/cl_set/cl_word_select/cl_byte_select/
//                 cl_op_size/cl_word_to_store, cl_fetched_word (read data back)
//   memory side : mem_req/mem_we/mem_addr/mem_size/mem_wdata,
//                 mem_ready/mem_rvalid/mem_rdata
// modport master = the cache controller, modport slave = CPU + array + memory.
package cache_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
endpackage

interface cache_controller_if #(
  parameter int XLEN             = 32,
  parameter int SET_SIZE         = 2,
  parameter int WORD_SELECT_SIZE = 3,
  parameter int BYTE_SELECT_SIZE = 2
);
  import cache_pkg::*;

  logic                        req_valid, req_ready, req_we;
  logic [XLEN-1:0]             req_addr, req_wdata;
  memory_operation_size_e      req_size;
  logic                        resp_valid, resp_err;
  logic [XLEN-1:0]             resp_rdata;

  logic                        cl_perform_write;
  logic [SET_SIZE-1:0]         cl_set;
  logic [WORD_SELECT_SIZE-1:0] cl_word_select;
  logic [BYTE_SELECT_SIZE-1:0] cl_byte_select;
  memory_operation_size_e      cl_op_size;
  logic [XLEN-1:0]             cl_word_to_store, cl_fetched_word;

  logic                        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [XLEN-1:0]             mem_addr, mem_wdata, mem_rdata;
  memory_operation_size_e      mem_size;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output cl_perform_write, cl_set, cl_word_select, cl_byte_select, cl_op_size, cl_word_to_store,
    input  cl_fetched_word,
    output mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  cl_perform_write, cl_set, cl_word_select, cl_byte_select, cl_op_size, cl_word_to_store,
    output cl_fetched_word,
    input  mem_req, mem_we, mem_addr, mem_size, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache control FSM.
// Holds tag/valid state, takes one CPU load/store at a time, refills a line
// word-serially from memory on a load miss and drives the external data
// array's selects/write strobe.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : cache_controller_if.master (CPU request/response, array, memory)
module cache_controller
  import cache_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int NUM_SETS         = 4,
  parameter int SET_SIZE         = 2,
  parameter int WORDS_PER_LINE   = 8,
  parameter int WORD_SELECT_SIZE = 3,
  parameter int BYTE_SELECT_SIZE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_controller_if.master bus
);

  localparam int TAG_SIZE = XLEN - SET_SIZE - WORD_SELECT_SIZE - BYTE_SELECT_SIZE;
  localparam int SET_LO   = WORD_SELECT_SIZE + BYTE_SELECT_SIZE;
  localparam int TAG_LO   = SET_LO + SET_SIZE;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, REPLAY, WT_REQ} state_e;

  state_e                      state_q, state_d;
  logic                        req_we_q, req_we_d;
  logic [XLEN-1:0]             req_addr_q, req_addr_d;
  logic [XLEN-1:0]             req_wdata_q, req_wdata_d;
  memory_operation_size_e      req_size_q, req_size_d;
  logic [NUM_SETS-1:0]         valid_q, valid_d;
  logic [WORD_SELECT_SIZE-1:0] fill_idx_q, fill_idx_d;
  logic [TAG_SIZE-1:0]         tag_q [NUM_SETS];
  logic                        tag_we;

  logic [TAG_SIZE-1:0]         req_tag;
  logic [SET_SIZE-1:0]         req_set;
  logic [WORD_SELECT_SIZE-1:0] req_word;
  logic [BYTE_SELECT_SIZE-1:0] req_byte;
  logic                        hit, misaligned;

  assign req_tag  = req_addr_q[XLEN-1:TAG_LO];
  assign req_set  = req_addr_q[TAG_LO-1:SET_LO];
  assign req_word = req_addr_q[SET_LO-1:BYTE_SELECT_SIZE];
  assign req_byte = req_addr_q[BYTE_SELECT_SIZE-1:0];

  assign hit        = valid_q[req_set] && (tag_q[req_set] == req_tag);
  assign misaligned = ((req_size_q == HALF) && req_addr_q[0]) ||
                      ((req_size_q == WORD) && (req_addr_q[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_size_d  = req_size_q;
    valid_d     = valid_q;
    fill_idx_d  = fill_idx_q;
    tag_we      = 1'b0;

    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_rdata       = '0;
    bus.resp_err         = 1'b0;
    // Array selects default to the captured request so LOOKUP/REPLAY read it.
    bus.cl_perform_write = 1'b0;
    bus.cl_set           = req_set;
    bus.cl_word_select   = req_word;
    bus.cl_byte_select   = req_byte;
    bus.cl_op_size       = req_size_q;
    bus.cl_word_to_store = req_wdata_q;
    // mem_req decodes from state only: no mem_ready -> mem_req path, and all
    // memory fields come from flops so they hold while waiting for acceptance.
    bus.mem_req          = 1'b0;
    bus.mem_we           = 1'b0;
    bus.mem_addr         = req_addr_q;
    bus.mem_size         = req_size_q;
    bus.mem_wdata        = req_wdata_q;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          req_we_d    = bus.req_we;
          req_addr_d  = bus.req_addr;
          req_size_d  = bus.req_size;
          req_wdata_d = bus.req_wdata;
          state_d     = LOOKUP;
        end
      end

      LOOKUP: begin
        if (misaligned) begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = 1'b1;
          state_d        = IDLE;
        end else if (req_we_q) begin
          // Write-through: update the array only on a hit, memory always.
          bus.cl_perform_write = hit;
          state_d              = WT_REQ;
        end else if (hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = bus.cl_fetched_word;
          state_d        = IDLE;
        end else begin
          // Line is invalid for the whole refill so an aborted fill never
          // leaves a half-written line looking valid.
          valid_d[req_set] = 1'b0;
          fill_idx_d       = '0;
          state_d          = FILL_REQ;
        end
      end

      FILL_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_size = WORD;
        bus.mem_addr = {req_tag, req_set, fill_idx_q, {BYTE_SELECT_SIZE{1'b0}}};
        if (bus.mem_ready) state_d = FILL_WAIT;
      end

      FILL_WAIT: begin
        bus.cl_word_select   = fill_idx_q;
        bus.cl_byte_select   = '0;
        bus.cl_op_size       = WORD;
        bus.cl_word_to_store = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          bus.cl_perform_write = 1'b1;
          if (fill_idx_q == WORD_SELECT_SIZE'(WORDS_PER_LINE - 1)) begin
            tag_we           = 1'b1;
            valid_d[req_set] = 1'b1;
            state_d          = REPLAY;
          end else begin
            fill_idx_d = fill_idx_q + 1'b1;
            state_d    = FILL_REQ;
          end
        end
      end

      REPLAY: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = bus.cl_fetched_word;
        state_d        = IDLE;
      end

      WT_REQ: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ready) begin
          bus.resp_valid = 1'b1;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_size_q  <= BYTE;
      valid_q     <= '0;
      fill_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_size_q  <= req_size_d;
      valid_q     <= valid_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[req_set] <= req_tag;
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_controller_if #(.XLEN(32), .SET_SIZE(2), .WORD_SELECT_SIZE(3), .BYTE_SELECT_SIZE(2)) bus ();

  cache_controller #(
    .XLEN(32), .NUM_SETS(4), .SET_SIZE(2), .WORDS_PER_LINE(8),
    .WORD_SELECT_SIZE(3), .BYTE_SELECT_SIZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic                   we;
    logic [31:0]            addr;
    memory_operation_size_e sz;
    logic [31:0]            wd;
    logic                   err;
    logic [31:0]            rdata;
    int                     n_rd;
    int                     n_wr;
    int                     n_arr;
    logic [31:0]            rd_base;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  // ---- byte-lane helpers (array/memory semantics) ----
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] b,
                                          input memory_operation_size_e s);
    logic [31:0] sh;
    sh = w >> (8 * b);
    case (s)
      BYTE:    return {24'h0, sh[7:0]};
      HALF:    return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] b,
                                        input memory_operation_size_e s, input logic [31:0] d);
    logic [31:0] m;
    case (s)
      BYTE:    m = 32'h0000_00FF;
      HALF:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    m = m << (8 * b);
    return (old & ~m) | ((d << (8 * b)) & m);
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {16'hC0DE, a[15:2], 2'b00};
  endfunction

  // ---- data array model (combinational read, posedge write) ----
  logic [31:0] arr [4][8];
  always_comb bus.cl_fetched_word = extract(arr[bus.cl_set][bus.cl_word_select],
                                            bus.cl_byte_select, bus.cl_op_size);
  always @(posedge clk)
    if (bus.cl_perform_write)
      arr[bus.cl_set][bus.cl_word_select] <= merge(arr[bus.cl_set][bus.cl_word_select],
        bus.cl_byte_select, bus.cl_op_size, bus.cl_word_to_store);

  // ---- memory responder state ----
  logic [31:0] mem [int unsigned];
  logic [31:0] rdq [$];
  logic [31:0] rd_list [$];

  // ---- reference model: behavioural cache + memory image ----
  logic [31:0] ref_mem [int unsigned];
  logic [3:0]  ref_valid;
  logic [24:0] ref_tag [4];

  task automatic predict(input logic we, input logic [31:0] a, input memory_operation_size_e sz,
                         input logic [31:0] wd, output vec_t e);
    int set; logic [24:0] tag; logic h; logic [31:0] w;
    set = int'(a[6:5]); tag = a[31:7];
    h = ref_valid[set] && ref_tag[set] == tag;
    w = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : dflt(a);
    e.we = we; e.addr = a; e.sz = sz; e.wd = wd;
    e.err = 1'b0; e.rdata = 32'h0; e.n_rd = 0; e.n_wr = 0; e.n_arr = 0;
    e.rd_base = {a[31:5], 5'h0};
    if ((sz == HALF && a[0]) || (sz == WORD && a[1:0] != 2'b00)) e.err = 1'b1;
    else if (we) begin
      e.n_wr = 1; e.n_arr = h ? 1 : 0;
      ref_mem[a >> 2] = merge(w, a[1:0], sz, wd);
    end else begin
      e.rdata = extract(w, a[1:0], sz);
      if (!h) begin
        e.n_rd = 8; e.n_arr = 8;
        ref_valid[set] = 1'b1; ref_tag[set] = tag;
      end
    end
  endtask

  // ---- per-cycle driver / monitor ----
  logic                   drv_rst_n, drv_valid, drv_we;
  logic [31:0]            drv_addr, drv_wd;
  memory_operation_size_e drv_sz;
  int cyc = 0, acc_cyc = 0, n_rd, n_wr, n_arr;
  int stab_err = 0, busy_err = 0, stray = 0;
  logic in_txn = 1'b0, got_resp, accepted;
  logic r_err; logic [31:0] r_data;
  logic [31:0] wr_addr, wr_data; memory_operation_size_e wr_sz;
  logic hold_v = 1'b0, h_we; logic [31:0] h_addr, h_wd; memory_operation_size_e h_sz;

  task automatic tick();
    logic real_rv;
    @(negedge clk);
    rst_n = drv_rst_n;
    bus.req_valid = drv_valid; bus.req_we = drv_we; bus.req_addr = drv_addr;
    bus.req_size = drv_sz; bus.req_wdata = drv_wd;
    real_rv = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    if (rdq.size() != 0) begin
      if ($urandom_range(0, 2) != 0) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdq[0]; real_rv = 1'b1;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;  // stray, must be ignored
    end
    bus.mem_ready = ($urandom_range(0, 1) == 1);
    #4;
    cyc++;
    if (real_rv) rdq.delete(0);
    if (hold_v && (!bus.mem_req || bus.mem_addr !== h_addr || bus.mem_we !== h_we ||
                   bus.mem_wdata !== h_wd || bus.mem_size !== h_sz)) stab_err++;
    hold_v = bus.mem_req && !bus.mem_ready;
    h_addr = bus.mem_addr; h_we = bus.mem_we; h_wd = bus.mem_wdata; h_sz = bus.mem_size;
    if (bus.mem_req && bus.mem_ready) begin
      if (bus.mem_we) begin
        n_wr++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; wr_sz = bus.mem_size;
        mem[bus.mem_addr >> 2] = merge(mem.exists(bus.mem_addr >> 2) ? mem[bus.mem_addr >> 2]
                                       : dflt(bus.mem_addr), bus.mem_addr[1:0], bus.mem_size, bus.mem_wdata);
      end else begin
        n_rd++; rd_list.push_back(bus.mem_addr);
        rdq.push_back(mem.exists(bus.mem_addr >> 2) ? mem[bus.mem_addr >> 2] : dflt(bus.mem_addr));
      end
    end
    if (bus.cl_perform_write) n_arr++;
    if (in_txn && bus.req_ready) busy_err++;
    if (bus.resp_valid) begin
      if (!in_txn) stray++;
      else begin
        got_resp = 1'b1; r_err = bus.resp_err; r_data = bus.resp_rdata; in_txn = 1'b0;
      end
    end
    if (drv_valid && bus.req_ready && rst_n) begin
      in_txn = 1'b1; acc_cyc = cyc; accepted = 1'b1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clear_obs();
    n_rd = 0; n_wr = 0; n_arr = 0; rd_list.delete(); got_resp = 1'b0; accepted = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t e);
    int k; logic ok;
    clear_obs();
    drv_valid = 1'b1; drv_we = e.we; drv_addr = e.addr; drv_sz = e.sz; drv_wd = e.wd;
    k = 0;
    while (!got_resp && k < 300) begin
      tick();
      if (accepted) drv_valid = 1'b0;
      k++;
    end
    drv_valid = 1'b0;
    check($sformatf("%s:resp_seen", nm), 32'(got_resp), 32'd1);
    check($sformatf("%s:err", nm), 32'(r_err), 32'(e.err));
    check($sformatf("%s:rdata", nm), r_data, e.rdata);
    check($sformatf("%s:mem_reads", nm), n_rd, e.n_rd);
    check($sformatf("%s:mem_writes", nm), n_wr, e.n_wr);
    check($sformatf("%s:array_writes", nm), n_arr, e.n_arr);
    if (e.n_rd > 0) begin
      ok = 1'b1;
      foreach (rd_list[i]) if (rd_list[i] !== e.rd_base + 32'(4 * i)) ok = 1'b0;
      check($sformatf("%s:fill_order", nm), 32'(ok), 32'd1);
    end
    if (e.n_wr > 0) begin
      check($sformatf("%s:wr_addr", nm), wr_addr, e.addr);
      check($sformatf("%s:wr_data", nm), wr_data, e.wd);
      check($sformatf("%s:wr_size", nm), 32'(wr_sz), 32'(e.sz));
    end
    if (e.n_rd == 0 && (e.err || !e.we))
      check($sformatf("%s:latency", nm), cyc - acc_cyc, 1);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a, input memory_operation_size_e sz,
                              input logic [31:0] wd, input logic err, input logic [31:0] rd,
                              input int nr, input int nw, input int na);
    vec_t v;
    v.we = we; v.addr = a; v.sz = sz; v.wd = wd; v.err = err; v.rdata = rd;
    v.n_rd = nr; v.n_wr = nw; v.n_arr = na; v.rd_base = {a[31:5], 5'h0};
    return v;
  endfunction

  task automatic run_tbl(input string nm, input vec_t v);
    vec_t dummy;
    predict(v.we, v.addr, v.sz, v.wd, dummy);  // keep model state in step
    run_vec(nm, v);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ":req_ready"}, 32'(bus.req_ready), 32'd1);
    check({nm, ":resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({nm, ":mem_req"}, 32'(bus.mem_req), 32'd0);
    check({nm, ":cl_write"}, 32'(bus.cl_perform_write), 32'd0);
  endtask

  vec_t tbl [19];

  initial begin
    vec_t e; int k;
    rst_n = 1'b0; drv_rst_n = 1'b0; drv_valid = 1'b0; drv_we = 1'b0;
    drv_addr = 32'h0; drv_wd = 32'h0; drv_sz = WORD;
    ref_valid = 4'h0;
    clear_obs();

    tbl[0]  = mk(0, 32'h24,  WORD, 32'h0,        0, 32'hC0DE_0024, 8, 0, 8);
    tbl[1]  = mk(0, 32'h24,  WORD, 32'h0,        0, 32'hC0DE_0024, 0, 0, 0);
    tbl[2]  = mk(1, 32'h26,  BYTE, 32'hA5,       0, 32'h0,         0, 1, 1);
    tbl[3]  = mk(0, 32'h24,  WORD, 32'h0,        0, 32'hC0A5_0024, 0, 0, 0);
    tbl[4]  = mk(0, 32'h26,  BYTE, 32'h0,        0, 32'h0000_00A5, 0, 0, 0);
    tbl[5]  = mk(0, 32'h26,  HALF, 32'h0,        0, 32'h0000_C0A5, 0, 0, 0);
    tbl[6]  = mk(1, 32'h100, WORD, 32'h1234_5678,0, 32'h0,         0, 1, 0);
    tbl[7]  = mk(0, 32'h100, WORD, 32'h0,        0, 32'h1234_5678, 8, 0, 8);
    tbl[8]  = mk(0, 32'h21,  HALF, 32'h0,        1, 32'h0,         0, 0, 0);
    tbl[9]  = mk(0, 32'h22,  WORD, 32'h0,        1, 32'h0,         0, 0, 0);
    tbl[10] = mk(1, 32'h21,  HALF, 32'hBEEF,     1, 32'h0,         0, 0, 0);
    tbl[11] = mk(0, 32'h3C,  WORD, 32'h0,        0, 32'hC0DE_003C, 0, 0, 0);
    tbl[12] = mk(1, 32'h28,  WORD, 32'hCAFE_F00D,0, 32'h0,         0, 1, 1);
    tbl[13] = mk(0, 32'h28,  WORD, 32'h0,        0, 32'hCAFE_F00D, 0, 0, 0);
    tbl[14] = mk(0, 32'h80,  WORD, 32'h0,        0, 32'hC0DE_0080, 8, 0, 8);
    tbl[15] = mk(0, 32'h100, WORD, 32'h0,        0, 32'h1234_5678, 8, 0, 8);
    tbl[16] = mk(0, 32'h102, HALF, 32'h0,        0, 32'h0000_1234, 0, 0, 0);
    tbl[17] = mk(1, 32'h106, HALF, 32'hABCD,     0, 32'h0,         0, 1, 1);
    tbl[18] = mk(0, 32'h104, WORD, 32'h0,        0, 32'hABCD_0104, 0, 0, 0);

    tick();
    check_reset_outputs("reset");
    drv_rst_n = 1'b1;
    tick();

    foreach (tbl[i]) run_tbl($sformatf("t%0d", i), tbl[i]);

    // Reset while waiting for fill word 3 of line 0x1A0.
    clear_obs();
    drv_valid = 1'b1; drv_we = 1'b0; drv_addr = 32'h1A0; drv_sz = WORD;
    k = 0;
    while (n_rd < 4 && k < 300) begin
      tick();
      if (accepted) drv_valid = 1'b0;
      k++;
    end
    drv_valid = 1'b0;
    check("midfill:reads", n_rd, 4);
    check("midfill:array_writes", n_arr, 3);
    drv_rst_n = 1'b0; rdq.delete(); in_txn = 1'b0; hold_v = 1'b0;
    tick();
    check_reset_outputs("midfill_rst");
    tick();
    drv_rst_n = 1'b1;
    tick();
    check("midfill:no_resp", 32'(got_resp), 32'd0);
    ref_valid = 4'h0;
    run_tbl("refill_1a0", mk(0, 32'h1A0, WORD, 32'h0, 0, 32'hC0DE_01A0, 8, 0, 8));
    run_tbl("refill_24",  mk(0, 32'h24,  WORD, 32'h0, 0, 32'hC0A5_0024, 8, 0, 8));

    for (int i = 0; i < 120; i++) begin
      logic [31:0] a; memory_operation_size_e sz; int b;
      sz = memory_operation_size_e'($urandom_range(0, 2));
      b  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == HALF) b = b & 2;
        if (sz == WORD) b = 0;
      end
      a = 32'($urandom_range(0, 2) * 128 + $urandom_range(0, 3) * 32 + $urandom_range(0, 7) * 4 + b);
      predict($urandom_range(0, 2) == 0, a, sz, $urandom(), e);
      run_vec($sformatf("r%0d", i), e);
    end

    check("mem_stable", stab_err, 0);
    check("ready_while_busy", busy_err, 0);
    check("stray_resp", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
